ctrl_sequencer: RTL
===================

Name: ctrl_sequencer

Overview:
Parametrised successor to the nibbler control decoder. It generates the fetch/execute phase internally instead of taking it as an input. It inserts configurable RAM wait states on memory-operand instructions and supports run/halt/single-step control. It also counts retired instructions. It sits between the program ROM instruction register and the datapath (PC, accumulator, ALU, flags, RAM, I/O buffers, output register), driving all datapath control lines.

Parameters:
RAM_WAIT, 0, extra EXEC cycles inserted for RAM-accessing opcodes (3,6,7,B,F); legal range 0..15.
CNT_W, 16, width of retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
run  in  1  1 = free-running execution; 0 = halt after the current instruction
step  in  1  single-cycle pulse; executes exactly one instruction when idle and run=0
instr  in  4  opcode from instruction register, stable from FETCH to end of EXEC
cflag  in  1  carry flag from flags register
zflag  in  1  zero flag from flags register
phase  out  1  0 in IDLE/FETCH, 1 in EXEC
halted  out  1  1 in IDLE
incPC, loadPC, loadA, loadF  out  1 each  datapath load/increment strobes
fun  out  3  ALU function select
csRAM, weRAM, OEALU, OEIn, OEOpr, loadO  out  1 each  RAM select/write, bus output enables, output register load
retired  out  CNT_W  count of completed instructions

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- State machine: IDLE, FETCH, EXEC, plus a 4-bit wait counter wcnt.
- Reset: state=IDLE, wcnt=0, retired=0. While reset is high and in IDLE, all control outputs are 0, phase=0, halted=1.
- IDLE:
  - All control outputs 0.
  - Next state is FETCH if run=1 or step=1; otherwise stay in IDLE.
- FETCH:
  - Asserts incPC=1 and OEALU=1 only; everything else 0.
  - Always goes to EXEC next cycle; wcnt cleared.
- EXEC control word, by opcode (unlisted signals 0, fun=000 unless stated):
  - 0 JC: loadPC if cflag=1, else incPC. 1 JNC: loadPC if cflag=0, else incPC.
  - 2 CMPI: loadF, fun=001, OEOpr. 3 CMPM: incPC, loadF, fun=001, csRAM.
  - 4 LIT: loadA, loadF, fun=010, OEOpr. 5 IN: loadA, loadF, fun=010, OEIn.
  - 6 LD: incPC, loadA, loadF, fun=010, csRAM. 7 ST: incPC, csRAM, weRAM, OEALU.
  - 8 JZ: loadPC if zflag=1, else incPC. 9 JNZ: loadPC if zflag=0, else incPC.
  - A ADDI: loadA, loadF, fun=011, OEOpr. B ADDM: incPC, loadA, loadF, fun=011, csRAM.
  - C JMP: loadPC. D OUT: OEALU, loadO.
  - E NANDI: loadA, loadF, fun=100, OEOpr. F NANDM: incPC, loadA, loadF, fun=100, csRAM.
- Wait states (memory opcodes 3,6,7,B,F with RAM_WAIT>0):
  - EXEC lasts RAM_WAIT+1 cycles.
  - While wcnt<RAM_WAIT: fun, csRAM, weRAM, OEALU, OEIn, OEOpr are held per the table; incPC, loadPC, loadA, loadF, loadO are forced 0; wcnt increments.
  - The final cycle (wcnt==RAM_WAIT) drives the full word.
  - Non-memory opcodes always take exactly 1 EXEC cycle.
- Completion (final EXEC cycle):
  - retired increments by 1, wrapping modulo 2^CNT_W.
  - Next state is FETCH if run=1, else IDLE.
- Latency: non-memory instruction = 2 cycles; memory instruction = 2+RAM_WAIT cycles.
- Flags are sampled combinationally in the final EXEC cycle only.
- Control inputs:
  - step outside IDLE is ignored; it is not queued.
  - run falling mid-instruction lets the instruction complete, then the sequencer enters IDLE.
  - run and step high together are treated as run.
- Reset asserted in any state returns to IDLE on the next edge. The in-flight instruction is abandoned and retired is not incremented.

Test Plan:
- Reset, then run=1 with instr=4 (LIT), RAM_WAIT=0 -> FETCH word {incPC,OEALU}, then EXEC {loadA,loadF,fun=010,OEOpr}; period 2 cycles; retired=1,2,3 at each completion.
- Branches, run=1: instr=0 with cflag=1 -> EXEC loadPC=1, incPC=0. instr=0 with cflag=0 -> incPC=1. Repeat for 1/8/9 against zflag (e.g. instr=9, zflag=0 -> loadPC=1).
- RAM_WAIT=2, instr=7 (ST) -> EXEC lasts 3 cycles with csRAM=weRAM=OEALU=1 throughout; incPC=1 only in the 3rd cycle; retired +1 once.
- run=0: one step pulse -> exactly FETCH, EXEC, then IDLE with halted=1 and retired=1. A second step pulse during EXEC is ignored.
- run dropped during the 2nd EXEC cycle of a RAM_WAIT=3 LD -> LD completes (loadA on its 4th EXEC cycle), then IDLE.
- reset pulsed mid-EXEC -> next cycle IDLE with all outputs 0, retired=0. CNT_W=4 with 16 instructions -> retired wraps to 0.

Source files
------------

// File: rtl/ctrl_sequencer_if.sv
//==============================================================================
// Module  : ctrl_sequencer_if
// Brief   : Run/step/opcode/flag inputs and datapath control lines of ctrl_sequencer.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface ctrl_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             step;
    logic [3:0]       instr;
    logic             cflag;
    logic             zflag;
    logic             phase;
    logic             halted;
    logic             incPC;
    logic             loadPC;
    logic             loadA;
    logic             loadF;
    logic [2:0]       fun;
    logic             csRAM;
    logic             weRAM;
    logic             OEALU;
    logic             OEIn;
    logic             OEOpr;
    logic             loadO;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, step, instr, cflag, zflag,
        output phase, halted, incPC, loadPC, loadA, loadF, fun,
               csRAM, weRAM, OEALU, OEIn, OEOpr, loadO, retired
    );

    modport slave (
        output run, step, instr, cflag, zflag,
        input  phase, halted, incPC, loadPC, loadA, loadF, fun,
               csRAM, weRAM, OEALU, OEIn, OEOpr, loadO, retired
    );
endinterface

`default_nettype wire

// File: rtl/ctrl_sequencer.sv
//==============================================================================
// Module  : ctrl_sequencer
// Brief   : Fetch/execute control sequencer with RAM wait states and run/step.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module ctrl_sequencer #(
    parameter int RAM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    ctrl_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_C = RAM_WAIT[3:0];

    state_t           state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             w_mem;
    logic             w_last;

    assign w_mem  = bus.instr inside {4'h3, 4'h6, 4'h7, 4'hB, 4'hF};
    assign w_last = !w_mem || (wcnt_q == WAIT_C);
    assign bus.retired = retired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wcnt_q    <= 4'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        retired_d  = retired_q;
        bus.phase  = 1'b0;
        bus.halted = 1'b0;
        bus.incPC  = 1'b0;
        bus.loadPC = 1'b0;
        bus.loadA  = 1'b0;
        bus.loadF  = 1'b0;
        bus.fun    = 3'b000;
        bus.csRAM  = 1'b0;
        bus.weRAM  = 1'b0;
        bus.OEALU  = 1'b0;
        bus.OEIn   = 1'b0;
        bus.OEOpr  = 1'b0;
        bus.loadO  = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.halted = 1'b1;
                if (bus.run || bus.step) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                bus.incPC = 1'b1;
                bus.OEALU = 1'b1;
                wcnt_d    = 4'd0;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                bus.phase = 1'b1;
                case (bus.instr)
                    4'h0: begin bus.loadPC = bus.cflag;  bus.incPC = !bus.cflag; end
                    4'h1: begin bus.loadPC = !bus.cflag; bus.incPC = bus.cflag;  end
                    4'h2: begin bus.loadF = 1'b1; bus.fun = 3'b001; bus.OEOpr = 1'b1; end
                    4'h3: begin
                        bus.incPC = 1'b1; bus.loadF = 1'b1; bus.fun = 3'b001; bus.csRAM = 1'b1;
                    end
                    4'h4: begin
                        bus.loadA = 1'b1; bus.loadF = 1'b1; bus.fun = 3'b010; bus.OEOpr = 1'b1;
                    end
                    4'h5: begin
                        bus.loadA = 1'b1; bus.loadF = 1'b1; bus.fun = 3'b010; bus.OEIn = 1'b1;
                    end
                    4'h6: begin
                        bus.incPC = 1'b1; bus.loadA = 1'b1; bus.loadF = 1'b1;
                        bus.fun   = 3'b010; bus.csRAM = 1'b1;
                    end
                    4'h7: begin
                        bus.incPC = 1'b1; bus.csRAM = 1'b1; bus.weRAM = 1'b1; bus.OEALU = 1'b1;
                    end
                    4'h8: begin bus.loadPC = bus.zflag;  bus.incPC = !bus.zflag; end
                    4'h9: begin bus.loadPC = !bus.zflag; bus.incPC = bus.zflag;  end
                    4'hA: begin
                        bus.loadA = 1'b1; bus.loadF = 1'b1; bus.fun = 3'b011; bus.OEOpr = 1'b1;
                    end
                    4'hB: begin
                        bus.incPC = 1'b1; bus.loadA = 1'b1; bus.loadF = 1'b1;
                        bus.fun   = 3'b011; bus.csRAM = 1'b1;
                    end
                    4'hC: bus.loadPC = 1'b1;
                    4'hD: begin bus.OEALU = 1'b1; bus.loadO = 1'b1; end
                    4'hE: begin
                        bus.loadA = 1'b1; bus.loadF = 1'b1; bus.fun = 3'b100; bus.OEOpr = 1'b1;
                    end
                    default: begin
                        bus.incPC = 1'b1; bus.loadA = 1'b1; bus.loadF = 1'b1;
                        bus.fun   = 3'b100; bus.csRAM = 1'b1;
                    end
                endcase

                // RAM wait cycles keep the bus enables steady but suppress every state-changing strobe
                if (!w_last) begin
                    bus.incPC  = 1'b0;
                    bus.loadPC = 1'b0;
                    bus.loadA  = 1'b0;
                    bus.loadF  = 1'b0;
                    bus.loadO  = 1'b0;
                    wcnt_d     = wcnt_q + 4'd1;
                end else begin
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = bus.run ? S_FETCH : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire
